// File: rtl/mux_sel_scheduler_pkg.sv
// Shared definitions for the mux select scheduler: state encoding, channel
// geometry and the enabled-channel search helpers.
// Latency: n/a (package). Backpressure: n/a.
// Contents: ST_IDLE/ST_DWELL, NCH/SEL_W, next_enabled(), first_enabled().
package mux_sched_pkg;

  localparam int NCH   = 4;
  localparam int SEL_W = 2;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_DWELL = 1'b1;

  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } nxt_t;

  // Next set bit strictly above cur. Scans downward so the lowest
  // qualifying index is the last one written.
  function automatic nxt_t next_enabled(input logic [NCH-1:0]   mask,
                                        input logic [SEL_W-1:0] cur);
    nxt_t r;
    r = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if ((i > int'(cur)) && mask[i]) begin
        r.found = 1'b1;
        r.idx   = SEL_W'(i);
      end
    end
    return r;
  endfunction

  // Lowest set bit; 0 when the mask is empty (callers never rely on that).
  function automatic logic [SEL_W-1:0] first_enabled(input logic [NCH-1:0] mask);
    logic [SEL_W-1:0] idx;
    idx = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (mask[i]) idx = SEL_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/mux_sel_scheduler_dwell_counter.sv
// Loadable down-counter with a zero flag, used to time the dwell per channel.
// Latency: load/dec take effect on the next clk edge; zero is decoded from the flop.
// Backpressure: none; clr > load > dec priority, dec saturates at zero.
// Ports: clk, rst_n, clr, load, load_val[W], dec -> cnt[W], zero.
module mux_dwell_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         zero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign zero = (cnt_q == '0);

endmodule

// File: rtl/mux_sel_scheduler.sv
// Round-robin select driver for a 4:1 mux: dwells on each enabled channel,
// captures the mux output once per channel, publishes a 4-bit sweep result.
// Latency: dwell cycles per channel; sample/sample_valid one cycle after the last capture.
// Backpressure: none; sample_valid is a single-cycle pulse with no ready.
// Ports: clk, rst_n, start, stop, en_mask[4], dwell[DWELL_W], mux_out ->
//        sel[2], sample[4], sample_valid, busy
//        (+ sample_parity when MUX_SCHED_PARITY_EN is defined).
module mux_sel_scheduler #(
  parameter int DWELL_W = 8,
  parameter int NCH     = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic [NCH-1:0]     en_mask,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               mux_out,
  output logic [1:0]         sel,
  output logic [NCH-1:0]     sample,
  output logic               sample_valid,
  output logic               busy
`ifdef MUX_SCHED_PARITY_EN
  ,
  output logic               sample_parity
`endif
);

  import mux_sched_pkg::*;

  logic [0:0]         state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [NCH-1:0]     shadow_q, shadow_d;
  logic [NCH-1:0]     mask_q, mask_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [NCH-1:0]     sample_q, sample_d;
  logic               sample_valid_q, sample_valid_d;

  logic               cnt_clr;
  logic               cnt_load;
  logic [DWELL_W-1:0] cnt_load_val;
  logic               cnt_dec;
  logic [DWELL_W-1:0] cnt_val;
  logic               cnt_zero;

  logic [DWELL_W-1:0] dwell_eff;
  logic [NCH-1:0]     shadow_cap;
  nxt_t               nxt;

  // A dwell of 0 would mean "no time on the channel"; run it as 1 cycle.
  assign dwell_eff = (dwell == '0) ? DWELL_W'(1) : dwell;

  mux_dwell_counter #(
    .W (DWELL_W)
  ) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (cnt_clr),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .cnt      (cnt_val),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d        = state_q;
    sel_d          = sel_q;
    shadow_d       = shadow_q;
    mask_d         = mask_q;
    dwell_d        = dwell_q;
    sample_d       = sample_q;
    sample_valid_d = 1'b0;
    cnt_clr        = 1'b0;
    cnt_load       = 1'b0;
    cnt_load_val   = dwell_q - DWELL_W'(1);
    cnt_dec        = 1'b0;

    // The mux is combinational, so mux_out already belongs to sel_q.
    shadow_cap         = shadow_q;
    shadow_cap[sel_q]  = mux_out;
    nxt                = next_enabled(mask_q, sel_q);

    case (state_q)
      ST_IDLE: begin
        // stop wins over a simultaneous start; an empty mask is not a sweep.
        if (start && !stop && (en_mask != '0)) begin
          mask_d       = en_mask;
          dwell_d      = dwell_eff;
          sel_d        = first_enabled(en_mask);
          shadow_d     = '0;
          cnt_load     = 1'b1;
          cnt_load_val = dwell_eff - DWELL_W'(1);
          state_d      = ST_DWELL;
        end
      end

      ST_DWELL: begin
        if (!cnt_zero) begin
          if (stop) begin
            state_d  = ST_IDLE;
            shadow_d = '0;
            cnt_clr  = 1'b1;
          end else begin
            cnt_dec = 1'b1;
          end
        end else if (nxt.found) begin
          // Mid-sweep capture: a stop here abandons the partial result.
          if (stop) begin
            state_d  = ST_IDLE;
            shadow_d = '0;
            cnt_clr  = 1'b1;
          end else begin
            sel_d    = nxt.idx;
            shadow_d = shadow_cap;
            cnt_load = 1'b1;
          end
        end else begin
          // Sweep end always commits, even with a coincident stop. Mask and
          // dwell are only re-sampled here so mid-sweep edits stay invisible.
          sample_d       = shadow_cap;
          sample_valid_d = 1'b1;
          mask_d         = en_mask;
          dwell_d        = dwell_eff;
          shadow_d       = '0;
          if (stop || (en_mask == '0)) begin
            state_d = ST_IDLE;
            cnt_clr = 1'b1;
          end else begin
            sel_d        = first_enabled(en_mask);
            cnt_load     = 1'b1;
            cnt_load_val = dwell_eff - DWELL_W'(1);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      sel_q          <= '0;
      shadow_q       <= '0;
      mask_q         <= '0;
      dwell_q        <= '0;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      sel_q          <= sel_d;
      shadow_q       <= shadow_d;
      mask_q         <= mask_d;
      dwell_q        <= dwell_d;
      sample_q       <= sample_d;
      sample_valid_q <= sample_valid_d;
    end
  end

`ifdef MUX_SCHED_PARITY_EN
  logic sample_parity_q, sample_parity_d;

  assign sample_parity_d = ^sample_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_parity_q <= 1'b0;
    end else begin
      sample_parity_q <= sample_parity_d;
    end
  end

  assign sample_parity = sample_parity_q;
`endif

  assign sel          = sel_q;
  assign sample       = sample_q;
  assign sample_valid = sample_valid_q;
  assign busy         = (state_q == ST_DWELL);

endmodule

// File: tb/tb_mux_sel_scheduler.sv
// Directed bench for mux_sel_scheduler with a behavioural 4:1 mux and a
// queue of expected sweep results popped on every sample_valid pulse.
module tb_mux_sel_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       stop;
  logic [3:0] en_mask;
  logic [7:0] dwell;
  logic [3:0] mux_in;
  logic       mux_out;
  logic [1:0] sel;
  logic [3:0] sample;
  logic       sample_valid;
  logic       busy;
`ifdef MUX_SCHED_PARITY_EN
  logic       sample_parity;
`endif

  int         n_vec = 0;
  int         n_err = 0;
  logic [3:0] sb_q[$];
  logic       got_valid;
  int         c;

  always #5 clk = ~clk;

  assign mux_out = mux_in[sel];

  mux_sel_scheduler #(
    .DWELL_W (8),
    .NCH     (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .stop         (stop),
    .en_mask      (en_mask),
    .dwell        (dwell),
    .mux_out      (mux_out),
    .sel          (sel),
    .sample       (sample),
    .sample_valid (sample_valid),
    .busy         (busy)
`ifdef MUX_SCHED_PARITY_EN
    ,
    .sample_parity (sample_parity)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; outputs are looked at 1 time unit after the edge.
  task automatic step();
    logic [3:0] e;
    @(posedge clk);
    #1;
    got_valid = sample_valid;
    if (sample_valid === 1'b1) begin
      chk("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk("sample", 32'(sample), 32'(e));
      end
    end
  endtask

  task automatic wait_valid(input int budget, output int cycles);
    cycles    = 0;
    got_valid = 1'b0;
    while (!got_valid && (cycles < budget)) begin
      step();
      cycles++;
    end
    chk("valid_timeout", 32'(got_valid), 32'd1);
  endtask

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    stop    = 1'b0;
    en_mask = 4'b0000;
    dwell   = 8'd0;
    mux_in  = 4'b0000;
    #12;
    chk("rst_sel",   32'(sel),          32'd0);
    chk("rst_sample", 32'(sample),      32'd0);
    chk("rst_valid", 32'(sample_valid), 32'd0);
    chk("rst_busy",  32'(busy),         32'd0);
`ifdef MUX_SCHED_PARITY_EN
    chk("rst_parity", 32'(sample_parity), 32'd0);
`endif
    rst_n = 1'b1;
    step();

    // Start with an empty mask does nothing.
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("empty_busy", 32'(busy), 32'd0);
    chk("empty_sel",  32'(sel),  32'd0);

    // Full mask, dwell 2, inputs 1010: sel 0,0,1,1,2,2,3,3.
    en_mask = 4'b1111;
    dwell   = 8'd2;
    mux_in  = 4'b1010;
    start   = 1'b1;
    step();
    start = 1'b0;
    chk("a_busy", 32'(busy), 32'd1);
    chk("a_sel0", 32'(sel),  32'd0);
    for (int i = 1; i < 8; i++) begin
      step();
      chk("a_sel", 32'(sel), 32'(i / 2));
    end
    sb_q.push_back(4'b1010);
    step();
    chk("a_valid", 32'(got_valid), 32'd1);
    chk("a_sel_wrap", 32'(sel), 32'd0);
    sb_q.push_back(4'b1010);
    wait_valid(20, c);
    chk("a_period", 32'(c), 32'd8);

    // Mid-sweep mask change while on channel 1: sweep still finishes 2 and 3.
    step();
    step();
    chk("m_sel1", 32'(sel), 32'd1);
    en_mask = 4'b0001;
    dwell   = 8'd3;
    sb_q.push_back(4'b1010);
    wait_valid(20, c);
    chk("m_tail", 32'(c), 32'd6);
    // Channel 0 only; disabled channels read 0 even with their inputs high.
    mux_in = 4'b1110;
    sb_q.push_back(4'b0000);
    wait_valid(20, c);
    chk("m_single_period", 32'(c), 32'd3);
    chk("m_single_sel", 32'(sel), 32'd0);

    // Switch to mask 1010 with dwell 0 (runs as 1); takes effect next sweep.
    en_mask = 4'b1010;
    dwell   = 8'd0;
    mux_in  = 4'b1111;
    sb_q.push_back(4'b0001);
    wait_valid(20, c);
    chk("d_old_period", 32'(c), 32'd3);
    chk("d_sel1", 32'(sel), 32'd1);
    sb_q.push_back(4'b1010);
    step();
    chk("d_sel3", 32'(sel), 32'd3);
    wait_valid(5, c);
    chk("d_edge", 32'(c), 32'd1);
    chk("d_sel1b", 32'(sel), 32'd1);
    sb_q.push_back(4'b1010);
    wait_valid(10, c);
    chk("d_period", 32'(c), 32'd2);

    // Stop on a mid-sweep capture: idle, sel holds, no commit.
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("s0_busy", 32'(busy), 32'd0);
    chk("s0_sel",  32'(sel),  32'd1);
    chk("s0_valid", 32'(got_valid), 32'd0);

    // Stop during channel 2 of the second sweep.
    en_mask = 4'b1111;
    dwell   = 8'd2;
    mux_in  = 4'b0110;
    start   = 1'b1;
    step();
    start = 1'b0;
    sb_q.push_back(4'b0110);
    wait_valid(20, c);
    chk("s1_period", 32'(c), 32'd8);
    mux_in = 4'b1001;
    for (int i = 0; i < 4; i++) step();
    chk("s1_sel2", 32'(sel), 32'd2);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("s1_busy", 32'(busy), 32'd0);
    chk("s1_sel_hold", 32'(sel), 32'd2);
    for (int i = 0; i < 5; i++) step();
    chk("s1_sample_kept", 32'(sample), 32'h6);

    // Start and stop together in idle: stop wins.
    start = 1'b1;
    stop  = 1'b1;
    step();
    start = 1'b0;
    stop  = 1'b0;
    chk("ss_busy", 32'(busy), 32'd0);

    // Stop coinciding with a sweep-end capture still commits.
    en_mask = 4'b0100;
    dwell   = 8'd1;
    mux_in  = 4'b0100;
    start   = 1'b1;
    step();
    start = 1'b0;
    chk("se_sel", 32'(sel), 32'd2);
    chk("se_busy_on", 32'(busy), 32'd1);
    stop = 1'b1;
    sb_q.push_back(4'b0100);
    step();
    stop = 1'b0;
    chk("se_valid", 32'(got_valid), 32'd1);
    chk("se_busy_off", 32'(busy), 32'd0);
    step();
    chk("se_valid_pulse", 32'(sample_valid), 32'd0);
    chk("se_sample", 32'(sample), 32'h4);

    // Sweep to 1011, then async reset mid-dwell.
    en_mask = 4'b1111;
    dwell   = 8'd2;
    mux_in  = 4'b1011;
    start   = 1'b1;
    step();
    start = 1'b0;
    sb_q.push_back(4'b1011);
    wait_valid(20, c);
    chk("r_period", 32'(c), 32'd8);
`ifdef MUX_SCHED_PARITY_EN
    chk("r_parity", 32'(sample_parity), 32'd1);
`endif
    step();
    step();
    step();
    chk("r_busy_pre", 32'(busy), 32'd1);
    chk("r_sel_pre", 32'(sel), 32'd1);
    rst_n = 1'b0;
    #2;
    chk("r_sel",    32'(sel),          32'd0);
    chk("r_sample", 32'(sample),       32'd0);
    chk("r_valid",  32'(sample_valid), 32'd0);
    chk("r_busy",   32'(busy),         32'd0);
`ifdef MUX_SCHED_PARITY_EN
    chk("r_parity_rst", 32'(sample_parity), 32'd0);
`endif
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mux_sel_scheduler.md
Name: mux_sel_scheduler

Overview:
Upstream control stage for the 4:1 mux datapath. It drives the 2-bit select, dwells a programmable number of cycles on each enabled channel, and samples the single-bit mux output. It assembles one bit per channel into a 4-bit sweep result and publishes the result once per full round-robin sweep. It sits directly before the mux (sel) and directly after it (the mux output returns as `mux_out`).

Parameters:
- DWELL_W, 8, width of the per-channel dwell count.
- NCH, 4, number of mux channels. Fixed at 4; sel width is 2.

Ports:
- clk, input, 1, single clock, rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, one-cycle request to begin continuous sweeping.
- stop, input, 1, one-cycle request to abort sweeping.
- en_mask, input, 4, channel enable; bit i enables mux input i.
- dwell, input, DWELL_W, cycles spent on each channel; 0 is treated as 1.
- mux_out, input, 1, output of the downstream 4:1 mux.
- sel, output, 2, mux select, registered.
- sample, output, 4, last completed sweep result; bit i is channel i; disabled channels read 0.
- sample_valid, output, 1, one-cycle pulse when `sample` updates.
- busy, output, 1, high while not in IDLE.

Behaviour:
- Interface: one clock (`clk`); reset is asynchronous and active-low (`rst_n`).
- Reset values: state=IDLE, sel=0, sample=0, sample_valid=0, busy=0. Internal shadow, counter and latched mask/dwell are all cleared.
- States:
  - IDLE: waiting for start.
  - DWELL: counting on the current channel.
- IDLE, start=1, en_mask!=0, stop=0:
  - Latch mask_q=en_mask and dwell_q=max(dwell,1).
  - sel <= lowest enabled index; cnt <= dwell_q-1; shadow <= 0; go to DWELL.
  - busy goes high the next cycle.
- IDLE, start with en_mask==0: ignored, stay IDLE. Start and stop in the same cycle in IDLE: stop wins.
- DWELL, cnt!=0: cnt decrements; sel holds.
- DWELL, cnt==0 (capture cycle): shadow[sel] <= mux_out. The mux is combinational, so mux_out reflects the current sel.
  - If sel is not the highest enabled channel in mask_q: sel <= next higher enabled index; cnt <= dwell_q-1.
  - If sel is the highest enabled channel (sweep end):
    - sample <= shadow with the captured bit merged in; sample_valid=1 for the next cycle only.
    - Relatch mask_q/dwell_q from the inputs. If the new en_mask==0, go to IDLE.
    - Otherwise sel <= lowest enabled index, clear shadow, cnt <= new dwell_q-1.
- Per-channel latency is dwell_q cycles. Sweep period is dwell_q × popcount(mask_q) cycles.
- en_mask and dwell changes mid-sweep have no effect until the next sweep boundary.
- Single enabled channel: every capture is a sweep end; sample_valid pulses every dwell_q cycles.
- stop in DWELL:
  - Return to IDLE next cycle; busy=0; sel holds its last value.
  - Partial shadow is discarded; sample retains the last completed sweep.
  - If stop coincides with a sweep-end capture, the sweep commits (sample updates, sample_valid pulses), then IDLE.
- start while busy: ignored.
- Async reset mid-sweep: all state clears immediately; no sample_valid.

Optional Feature:
- MUX_SCHED_PARITY_EN: adds output sample_parity (1 bit), registered alongside sample, equal to the XOR of the 4 committed sample bits. Reset value 0.
- Without the macro: no port and no logic.

Decomposition:
- Shared package mux_sched_pkg holds:
  - state encoding constants ST_IDLE and ST_DWELL;
  - NCH=4 and SEL_W=2;
  - a function next_enabled(mask, cur) returning the next higher set index, with a found flag;
  - a function first_enabled(mask).
- One natural sub-module: mux_dwell_counter (loadable down-counter with zero flag).

Test Plan:
- Reset then idle: all outputs 0; start with en_mask=4'b0000 -> busy stays 0, sel=0.
- en_mask=4'b1111, dwell=2, mux inputs 4'b1010 -> sel steps 0,0,1,1,2,2,3,3 (two cycles each). sample_valid pulses 1 cycle after the channel-3 capture; sample=4'b1010; period 8 cycles.
- en_mask=4'b1010, dwell=0 (treated as 1), inputs 4'b1111 -> sel alternates 1,3; sample=4'b1010; sample_valid every 2 cycles.
- Mid-sweep mask change 4'b1111 -> 4'b0001 during channel 1 -> current sweep completes over channels 2 and 3. The next sweep uses channel 0 only; sample_valid every dwell cycles.
- stop during channel 2 of the second sweep -> IDLE next cycle; no sample_valid; sample equals the first sweep's value. Stop on the sweep-end capture -> sample commits, then IDLE.
- rst_n asserted mid-DWELL -> sel, sample, sample_valid and busy go to 0 asynchronously. With MUX_SCHED_PARITY_EN defined, sample=4'b1011 -> sample_parity=1.
